// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor and its instruction fetch sequencer.
package proc_pkg;

  localparam int DATA_W = 9;
  localparam int ADDR_W = 5;
  localparam int TMR_W  = 8;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    FETCH1,
    FETCH2,
    ISSUE,
    WAIT_DONE
  } fetch_state_e;

  function automatic logic [2:0] opcode_of(input logic [DATA_W-1:0] word);
    return word[DATA_W-1 -: 3];
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Loadable down-counter; expired while the count sits at zero.
module fetch_timer
  import proc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [TMR_W-1:0] value_i,
  output logic             expired_o
);

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch sequencer: walks the instruction ROM, presents each instruction (and mvi immediate)
// on DIN with a one-cycle Run pulse, then waits for the processor's Done.
module instr_fetch_seq
  import proc_pkg::*;
#(
  parameter int unsigned ROM_LATENCY  = 1,
  parameter int unsigned DONE_TIMEOUT = 15,
  parameter logic [2:0]  MVI_OPCODE   = OP_MVI
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [DATA_W-1:0] MemData,
  input  logic              Done,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Error
);

  // Sync ROM samples the address one edge after it changes, so a fetch lasts ROM_LATENCY+1 cycles.
  localparam logic [TMR_W-1:0] LAT_LOAD  = TMR_W'(ROM_LATENCY);
  localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(DONE_TIMEOUT - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_value;
  logic              tmr_expired;
  logic              ir_is_mvi;
  logic [ADDR_W-1:0] pc_inc;

  fetch_timer u_timer (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .expired_o (tmr_expired)
  );

  assign ir_is_mvi = (opcode_of(ir_q) == MVI_OPCODE);
  assign pc_inc    = pc_q + (ir_is_mvi ? ADDR_W'(2) : ADDR_W'(1));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    addr_d    = addr_q;
    din_d     = din_q;
    run_d     = 1'b0;
    error_d   = error_q;
    tmr_load  = 1'b0;
    tmr_value = '0;

    unique case (state_q)
      IDLE: begin
        if (Enable && !error_q) begin
          state_d   = FETCH1;
          addr_d    = pc_q;
          tmr_load  = 1'b1;
          tmr_value = LAT_LOAD;
        end
      end
      FETCH1: begin
        if (tmr_expired) begin
          ir_d = MemData;
          if (opcode_of(MemData) == MVI_OPCODE) begin
            state_d   = FETCH2;
            addr_d    = pc_q + ADDR_W'(1);
            tmr_load  = 1'b1;
            tmr_value = LAT_LOAD;
          end else begin
            state_d = ISSUE;
            din_d   = MemData;
            run_d   = 1'b1;
          end
        end
      end
      FETCH2: begin
        if (tmr_expired) begin
          imm_d   = MemData;
          state_d = ISSUE;
          din_d   = ir_q;
          run_d   = 1'b1;
        end
      end
      ISSUE: begin
        state_d   = WAIT_DONE;
        din_d     = ir_is_mvi ? imm_q : ir_q;
        tmr_load  = 1'b1;
        tmr_value = WAIT_LOAD;
      end
      WAIT_DONE: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (Done) begin
          pc_d = pc_inc;
          if (Enable) begin
            state_d   = FETCH1;
            addr_d    = pc_inc;
            tmr_load  = 1'b1;
            tmr_value = LAT_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else if (tmr_expired) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  assign MemAddr = addr_q;
  assign DIN     = din_q;
  assign Run     = run_q;
  assign Busy    = busy_q;
  assign Error   = error_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: sync ROM and processor Done models, table vectors, random program.
module tb_instr_fetch_seq;
  import proc_pkg::*;

  localparam int L = 1;
  localparam int T = 15;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b0;
  logic       Done = 1'b0;
  logic [8:0] MemData = '0;
  logic [4:0] MemAddr;
  logic [8:0] DIN;
  logic       Run, Busy, Error;

  instr_fetch_seq #(.ROM_LATENCY(L), .DONE_TIMEOUT(T), .MVI_OPCODE(OP_MVI)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .MemData(MemData), .Done(Done),
    .MemAddr(MemAddr), .DIN(DIN), .Run(Run), .Busy(Busy), .Error(Error)
  );

  always #5 Clock = ~Clock;

  logic [8:0] rom [32];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int extra_runs = 0;
  int unstable = 0;
  logic [4:0] exp_pc;

  typedef struct {
    logic [4:0] addr;
    logic [8:0] word;
    logic [8:0] imm;
    int         k;
    logic       en;
    logic [8:0] e_din_run;
    logic [8:0] e_din_next;
    logic [4:0] e_addr_run;
    logic [4:0] e_addr_after;
    logic       e_busy_after;
    int         e_lat;
  } vec_t;
  vec_t tv [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; the ROM returns the word for the address it saw before this edge.
  task automatic step();
    logic [4:0] a;
    a = MemAddr;
    @(posedge Clock);
    #1;
    MemData = rom[a];
    cyc++;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Enable = 1'b0; Done = 1'b0;
    step();
    Reset = 1'b0;
  endtask

  task automatic wait_run(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      Done = 1'b0;
      if (Run === 1'b1) ok = 1'b1;
    end
  endtask

  // Entered one cycle into FETCH1; returns one cycle after the Done cycle.
  task automatic do_instr(input int k, input logic en, input logic jitter,
                          output logic [8:0] din_run, output logic [8:0] din_next,
                          output logic [4:0] addr_run, output logic [4:0] addr_after,
                          output logic busy_after, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      step();
      Done = 1'b0;
      lat++;
      if (jitter) Enable = 1'($urandom_range(0, 1));
      if (Run === 1'b1) got = 1'b1;
    end
    check("run_seen", 32'(got), 32'd1);
    if (!got) begin
      din_run = 'x; din_next = 'x; addr_run = 'x; addr_after = 'x; busy_after = 1'bx;
      return;
    end
    din_run  = DIN;
    addr_run = MemAddr;
    din_next = 'x;
    for (int j = 1; j <= k; j++) begin
      step();
      if (Run !== 1'b0) extra_runs++;
      if (j == 1) din_next = DIN;
      else if (DIN !== din_next) unstable++;
      if (MemAddr !== addr_run) unstable++;
      Enable = (jitter && j < k) ? 1'($urandom_range(0, 1)) : en;
      Done   = (j == k);
    end
    step();
    Done = 1'b0;
    addr_after = MemAddr;
    busy_after = Busy;
    if (Run !== 1'b0) extra_runs++;
  endtask

  // Reference: word at PC, immediate at PC+1 for mvi, fetch takes (L+1) cycles per word.
  task automatic do_model_instr(input int k, input logic en, input logic jitter,
                                output logic [8:0] o_din_run, output logic [8:0] o_din_next,
                                output logic [4:0] o_addr_run);
    logic [8:0] w, imm;
    logic [4:0] nx, pc0, aa;
    logic       m, ba;
    int         exp_lat, lat;
    pc0 = exp_pc;
    w   = rom[pc0];
    nx  = pc0 + 5'd1;
    imm = rom[nx];
    m   = (w[8:6] == OP_MVI);
    exp_lat = (L + 1) + (m ? L + 1 : 0);
    do_instr(k, en, jitter, o_din_run, o_din_next, o_addr_run, aa, ba, lat);
    check("m_din_run", 32'(o_din_run), 32'(w));
    check("m_din_next", 32'(o_din_next), 32'(m ? imm : w));
    check("m_addr_run", 32'(o_addr_run), 32'(m ? nx : pc0));
    check("m_latency", 32'(lat), 32'(exp_lat));
    exp_pc = pc0 + (m ? 5'd2 : 5'd1);
    check("m_addr_after", 32'(aa), 32'(en ? exp_pc : (m ? nx : pc0)));
    check("m_busy_after", 32'(ba), 32'(en));
  endtask

  task automatic idle_gap(input int g);
    int bad;
    bad = 0;
    for (int i = 0; i < g; i++) begin
      Enable = 1'b0;
      Done = 1'($urandom_range(0, 1));
      step();
      if (Run !== 1'b0 || Busy !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);
  endtask

  task automatic resume();
    Enable = 1'b1;
    Done = 1'($urandom_range(0, 1));
    step();
    Done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] dr, dn, e_din;
    logic [4:0] ar, aa;
    logic       ba, ok, en_r;
    int         lat, early, bad;

    tv[0] = '{5'd0, 9'o003, 9'h000, 2,  1'b1, 9'o003, 9'o003, 5'd0, 5'd1, 1'b1, 2};
    tv[1] = '{5'd1, 9'o211, 9'h000, 1,  1'b1, 9'o211, 9'o211, 5'd1, 5'd2, 1'b1, 2};
    tv[2] = '{5'd2, 9'o312, 9'h000, 3,  1'b1, 9'o312, 9'o312, 5'd2, 5'd3, 1'b1, 2};
    tv[3] = '{5'd3, 9'o045, 9'h000, 1,  1'b1, 9'o045, 9'o045, 5'd3, 5'd4, 1'b1, 2};
    tv[4] = '{5'd4, 9'o120, 9'h05A, 2,  1'b1, 9'o120, 9'h05A, 5'd5, 5'd6, 1'b1, 4};
    tv[5] = '{5'd6, 9'o000, 9'h000, 4,  1'b1, 9'o000, 9'o000, 5'd6, 5'd7, 1'b1, 2};
    tv[6] = '{5'd7, 9'o107, 9'h1FF, 1,  1'b1, 9'o107, 9'h1FF, 5'd8, 5'd9, 1'b1, 4};
    tv[7] = '{5'd9, 9'o376, 9'h000, 15, 1'b0, 9'o376, 9'o376, 5'd9, 5'd9, 1'b0, 2};

    for (int i = 0; i < 32; i++) rom[i] = '0;
    for (int i = 0; i < 8; i++) begin
      rom[tv[i].addr] = tv[i].word;
      if (tv[i].word[8:6] == OP_MVI) rom[tv[i].addr + 5'd1] = tv[i].imm;
    end

    do_reset();
    check("reset_outputs", 32'({MemAddr, DIN, Run, Busy, Error}), 32'd0);
    Enable = 1'b1;
    step();
    check("first_fetch_busy", 32'(Busy), 32'd1);
    check("first_fetch_addr", 32'(MemAddr), 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_instr(tv[i].k, tv[i].en, 1'b0, dr, dn, ar, aa, ba, lat);
      check($sformatf("t%0d_din_run", i), 32'(dr), 32'(tv[i].e_din_run));
      check($sformatf("t%0d_din_next", i), 32'(dn), 32'(tv[i].e_din_next));
      check($sformatf("t%0d_addr_run", i), 32'(ar), 32'(tv[i].e_addr_run));
      check($sformatf("t%0d_addr_after", i), 32'(aa), 32'(tv[i].e_addr_after));
      check($sformatf("t%0d_busy_after", i), 32'(ba), 32'(tv[i].e_busy_after));
      check($sformatf("t%0d_latency", i), 32'(lat), 32'(tv[i].e_lat));
    end
    check("done_at_timeout_no_error", 32'(Error), 32'd0);
    idle_gap(3);

    // Walk plain instructions up to an mvi at address 31 whose immediate wraps to address 0.
    for (int i = 10; i < 31; i++) rom[i] = {($urandom_range(0, 1) != 0) ? OP_ADD : OP_SUB, 6'(i)};
    rom[31] = 9'o155;
    rom[0]  = 9'h0FF;
    exp_pc  = 5'd10;
    resume();
    for (int n = 0; n < 21; n++) do_model_instr($urandom_range(1, 4), 1'b1, 1'b0, dr, dn, ar);
    do_model_instr(2, 1'b0, 1'b0, dr, dn, ar);
    check("wrap_din_run", 32'(dr), 32'(9'o155));
    check("wrap_imm_addr", 32'(ar), 32'd0);
    check("wrap_imm_data", 32'(dn), 32'(9'h0FF));
    idle_gap(2);

    for (int i = 0; i < 32; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) op = OP_MVI;
      rom[i] = {op, 6'($urandom)};
    end
    resume();
    for (int n = 0; n < 120; n++) begin
      en_r = ($urandom_range(0, 4) != 0);
      do_model_instr($urandom_range(1, T), en_r, 1'b1, dr, dn, ar);
      if (!en_r) begin
        idle_gap($urandom_range(1, 3));
        resume();
      end
    end
    do_model_instr(1, 1'b0, 1'b0, dr, dn, ar);
    check("no_error_random", 32'(Error), 32'd0);

    // Done withheld: Error after T waiting cycles, sticky until Reset.
    do_reset();
    rom[0] = {OP_MV, 6'o03};
    Enable = 1'b1;
    step();
    wait_run(ok);
    check("to_run_seen", 32'(ok), 32'd1);
    early = 0;
    for (int j = 1; j <= T; j++) begin
      step();
      if (Error !== 1'b0) early++;
    end
    check("to_error_early", 32'(early), 32'd0);
    step();
    check("to_error_set", 32'(Error), 32'd1);
    check("to_busy_clear", 32'(Busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      Enable = 1'b1;
      Done = 1'($urandom_range(0, 1));
      step();
      if (Run !== 1'b0 || Busy !== 1'b0 || Error !== 1'b1) bad++;
    end
    check("to_sticky_no_run", 32'(bad), 32'd0);
    do_reset();
    check("to_error_cleared", 32'({Error, Busy, Run}), 32'd0);

    // Reset while fetching the immediate.
    rom[0] = 9'o120;
    rom[1] = 9'h033;
    rom[2] = {OP_ADD, 6'o12};
    Enable = 1'b1;
    step();
    step();
    step();
    check("f2_addr", 32'(MemAddr), 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("f2_reset_outputs", 32'({MemAddr, DIN, Run, Busy, Error}), 32'd0);
    idle_gap(2);
    resume();
    exp_pc = 5'd0;
    do_model_instr(2, 1'b1, 1'b0, dr, dn, ar);

    // Reset while waiting for Done on the instruction at address 2.
    wait_run(ok);
    check("wd_run_seen", 32'(ok), 32'd1);
    e_din = rom[2];
    check("wd_din", 32'(DIN), 32'(e_din));
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("wd_reset_outputs", 32'({MemAddr, DIN, Run, Busy, Error}), 32'd0);
    resume();
    exp_pc = 5'd0;
    do_model_instr(1, 1'b0, 1'b0, dr, dn, ar);

    check("no_extra_run", 32'(extra_runs), 32'd0);
    check("wait_outputs_stable", 32'(unstable), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
